// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
// Optional perf counters are enabled with MEM_ARB_PERF_EN.
package mem_arb_pkg;

    typedef logic master_id_t;

    localparam master_id_t M_IF  = 1'b0;
    localparam master_id_t M_LSU = 1'b1;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;
    localparam int unsigned RUN_W  = 4;

    localparam logic [BE_W-1:0] WEB_READ = 4'b1111;

    typedef struct packed {
        logic [DATA_W-1:0] addr;
        logic [BE_W-1:0]   web;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Saturating increment so the run length can never wrap back below the cap
    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] r);
        return (r == {RUN_W{1'b1}}) ? r : r + RUN_W'(1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select: round-robin pointer plus run-length cap.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_RUN = 4
) (
    input  logic             req0,
    input  logic             req1,
    input  master_id_t       prio,
    input  master_id_t       last,
    input  logic [RUN_W-1:0] run,
    output logic             gnt0_c,
    output logic             gnt1_c
);

    master_id_t win_c;

    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        win_c  = prio;
        if (req0 && req1) begin
            // A master that has hit the cap yields to the other one
            if (run == RUN_W'(MAX_RUN)) begin
                win_c = ~last;
            end
            gnt0_c = (win_c == M_IF);
            gnt1_c = (win_c == M_LSU);
        end else begin
            gnt0_c = req0;
            gnt1_c = req1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch (m0) and load/store (m1).
// Define MEM_ARB_PERF_EN to add grant/conflict performance counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned MAX_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [BE_W-1:0]   m0_web,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [BE_W-1:0]   m1_web,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              sram_cs,
    output logic              sram_oe,
    output logic [BE_W-1:0]   sram_web,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_di,
`ifdef MEM_ARB_PERF_EN
    output logic [DATA_W-1:0] perf_gnt0,
    output logic [DATA_W-1:0] perf_gnt1,
    output logic [DATA_W-1:0] perf_conf,
`endif
    input  logic [DATA_W-1:0] sram_do
);

    logic              req0_c;
    logic              req1_c;
    logic              gnt0_c;
    logic              gnt1_c;
    logic              gnt_any_c;
    logic              other_req_c;
    master_id_t        gnt_id_c;
    mem_req_t          m0_bus_c;
    mem_req_t          m1_bus_c;
    mem_req_t          sel_c;

    master_id_t        prio;
    master_id_t        last;
    master_id_t        rd_id;
    logic [RUN_W-1:0]  run;
    logic              rd_pend;
    logic [ADDR_W-1:0] sram_a_q;
    logic [DATA_W-1:0] sram_di_q;
    logic [DATA_W-1:0] m0_rdata_q;
    logic [DATA_W-1:0] m1_rdata_q;

    logic              unused_addr_bits;

    // No grant may escape while reset is asserted
    assign req0_c = m0_req & ~rst;
    assign req1_c = m1_req & ~rst;

    mem_arb_pick #(
        .MAX_RUN (MAX_RUN)
    ) u_pick (
        .req0   (req0_c),
        .req1   (req1_c),
        .prio   (prio),
        .last   (last),
        .run    (run),
        .gnt0_c (gnt0_c),
        .gnt1_c (gnt1_c)
    );

    always_comb begin
        m0_bus_c    = '{addr: m0_addr, web: m0_web, wdata: m0_wdata};
        m1_bus_c    = '{addr: m1_addr, web: m1_web, wdata: m1_wdata};
        sel_c       = gnt1_c ? m1_bus_c : m0_bus_c;
        gnt_any_c   = gnt0_c | gnt1_c;
        gnt_id_c    = gnt1_c ? M_LSU : M_IF;
        other_req_c = gnt1_c ? req0_c : req1_c;
    end

    // Only the word-address bits reach the SRAM
    assign unused_addr_bits = ^sel_c.addr;

    // SRAM side holds address/data when idle so the pins do not toggle
    always_comb begin
        m0_gnt   = gnt0_c;
        m1_gnt   = gnt1_c;
        sram_oe  = 1'b1;
        sram_cs  = gnt_any_c;
        sram_web = WEB_READ;
        sram_a   = sram_a_q;
        sram_di  = sram_di_q;
        if (gnt_any_c) begin
            sram_web = sel_c.web;
            sram_a   = sel_c.addr[ADDR_W+1:2];
            sram_di  = sel_c.wdata;
        end
        m0_rvalid = rd_pend & (rd_id == M_IF);
        m1_rvalid = rd_pend & (rd_id == M_LSU);
        m0_rdata  = m0_rvalid ? sram_do : m0_rdata_q;
        m1_rdata  = m1_rvalid ? sram_do : m1_rdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio       <= M_LSU;
            last       <= M_LSU;
            run        <= '0;
            rd_pend    <= 1'b0;
            rd_id      <= M_IF;
            sram_a_q   <= '0;
            sram_di_q  <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            if (gnt_any_c) begin
                prio <= ~gnt_id_c;
                last <= gnt_id_c;
                run  <= ((gnt_id_c == last) && other_req_c) ? run_inc(run) : RUN_W'(1);
            end
            rd_pend    <= gnt_any_c && (sel_c.web == WEB_READ);
            rd_id      <= gnt_id_c;
            sram_a_q   <= sram_a;
            sram_di_q  <= sram_di;
            m0_rdata_q <= m0_rdata;
            m1_rdata_q <= m1_rdata;
        end
    end

`ifdef MEM_ARB_PERF_EN
    // Free-running counters, wrap naturally at 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_gnt0 <= '0;
            perf_gnt1 <= '0;
            perf_conf <= '0;
        end else begin
            perf_gnt0 <= perf_gnt0 + DATA_W'(gnt0_c);
            perf_gnt1 <= perf_gnt1 + DATA_W'(gnt1_c);
            perf_conf <= perf_conf + DATA_W'(req0_c & req1_c);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural SRAM and a read-return scoreboard.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned ADDR_W  = 14;
    localparam int unsigned MAX_RUN = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m1_req;
    logic [31:0]       m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]        m0_web, m1_web;
    logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0]       m0_rdata, m1_rdata;
    logic              sram_cs, sram_oe;
    logic [3:0]        sram_web;
    logic [ADDR_W-1:0] sram_a;
    logic [31:0]       sram_di;
    logic [31:0]       sram_do;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_gnt0, perf_gnt1, perf_conf;
`endif

    logic              pk_req0, pk_req1, pk_prio, pk_last, pk_gnt0, pk_gnt1;
    logic [3:0]        pk_run;

    typedef struct {
        logic        id;
        logic [31:0] data;
    } rd_exp_t;

    rd_exp_t     sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem     [256];
    logic [31:0] exp_mem [256];
    logic        init_mem;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .MAX_RUN(MAX_RUN)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_web(m0_web), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_web(m1_web), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .sram_cs(sram_cs), .sram_oe(sram_oe), .sram_web(sram_web),
        .sram_a(sram_a), .sram_di(sram_di),
`ifdef MEM_ARB_PERF_EN
        .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conf(perf_conf),
`endif
        .sram_do(sram_do)
    );

    mem_arb_pick #(.MAX_RUN(MAX_RUN)) u_pick (
        .req0(pk_req0), .req1(pk_req1), .prio(pk_prio), .last(pk_last),
        .run(pk_run), .gnt0_c(pk_gnt0), .gnt1_c(pk_gnt1)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
    endfunction

    // Behavioural SRAM: 1-cycle read latency, active-low byte lanes, junk on sram_do when idle
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (sram_cs) begin
            for (int b = 0; b < 4; b++)
                if (!sram_web[b]) mem[sram_a[7:0]][8*b +: 8] <= sram_di[8*b +: 8];
            if (sram_web == WEB_READ) sram_do <= mem[sram_a[7:0]];
            else                      sram_do <= $urandom;
        end else begin
            sram_do <= $urandom;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m0(input logic r, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        m0_req = r; m0_addr = a; m0_web = w; m0_wdata = d;
    endtask

    task automatic drive_m1(input logic r, input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        m1_req = r; m1_addr = a; m1_web = w; m1_wdata = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_m0(1'b0, 32'h0, WEB_READ, 32'h0);
        drive_m1(1'b0, 32'h0, WEB_READ, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        drive_m0(1'b1, 32'h4, WEB_READ, 32'h0);
        drive_m1(1'b1, 32'h8, WEB_READ, 32'h0);
        tick();
        init_mem = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_cs, sram_oe} !== 6'b000001) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000001", {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_cs, sram_oe});
        end
        n_checks++;
        if ({sram_web, sram_a, sram_di} !== {4'hF, {(ADDR_W+32){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_sram: web %h a %h di %h want f/0/0", sram_web, sram_a, sram_di);
        end
        n_checks++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h want 0 0", m0_rdata, m1_rdata);
        end
        drive_m0(1'b0, 32'h0, WEB_READ, 32'h0);
        drive_m1(1'b0, 32'h0, WEB_READ, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({m0_rvalid, m1_rvalid, sram_cs} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b want 000", {m0_rvalid, m1_rvalid, sram_cs});
        end
        tick();
    endtask

    task automatic test_single_read();
        rd_exp_t e;
        drive_m0(1'b1, 32'h0000_0010, WEB_READ, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt, sram_cs, sram_web, sram_a} !== {3'b101, 4'hF, 14'd4}) begin
            n_fail++;
            $display("FAIL single_gnt: gnt %b%b cs %b web %h a %0d want 10 1 f 4", m0_gnt, m1_gnt, sram_cs, sram_web, sram_a);
        end
        sb.push_back('{id: 1'b0, data: exp_mem[4]});
        tick();
        drive_m0(1'b0, 32'h0, WEB_READ, 32'h0);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== e.data) begin
            n_fail++;
            $display("FAIL single_rvalid: rv %b%b data %h want 10 %h", m0_rvalid, m1_rvalid, m0_rdata, e.data);
        end
        n_checks++;
        if ({sram_cs, sram_web, sram_a} !== {1'b0, 4'hF, 14'd4}) begin
            n_fail++;
            $display("FAIL idle_hold_addr: cs %b web %h a %0d want 0 f 4", sram_cs, sram_web, sram_a);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== e.data) begin
            n_fail++;
            $display("FAIL rdata_hold: rv %b data %h want 0 %h", m0_rvalid, m0_rdata, e.data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        rd_exp_t     e;
        logic        prio_m;
        logic        w;
        logic [31:0] a0, a1, aw;
        do_reset();
        a0 = 32'h40; a1 = 32'h80; prio_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_m0(1'b1, a0, WEB_READ, 32'h0);
            drive_m1(1'b1, a1, WEB_READ, 32'h0);
            @(negedge clk);
            w  = prio_m;
            aw = w ? a1 : a0;
            n_checks++;
            if ({m0_gnt, m1_gnt} !== (w ? 2'b01 : 2'b10) || sram_a !== aw[ADDR_W+1:2]) begin
                n_fail++;
                $display("FAIL rr_gnt[%0d]: gnt %b%b a %0d want m%0d a %0d", i, m0_gnt, m1_gnt, sram_a, w, aw[ADDR_W+1:2]);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({m0_rvalid, m1_rvalid} !== (e.id ? 2'b01 : 2'b10) || (e.id ? m1_rdata : m0_rdata) !== e.data) begin
                    n_fail++;
                    $display("FAIL rr_rvalid[%0d]: rv %b%b data %h/%h want m%0d %h", i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, e.id, e.data);
                end
            end
            sb.push_back('{id: w, data: exp_mem[aw[9:2]]});
            if (w) a1 = a1 + 32'd4; else a0 = a0 + 32'd4;
            prio_m = ~w;
            tick();
        end
        drive_m0(1'b0, 32'h0, WEB_READ, 32'h0);
        drive_m1(1'b0, 32'h0, WEB_READ, 32'h0);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if ({m0_rvalid, m1_rvalid} !== (e.id ? 2'b01 : 2'b10) || (e.id ? m1_rdata : m0_rdata) !== e.data) begin
            n_fail++;
            $display("FAIL rr_last_rvalid: rv %b%b want m%0d %h", m0_rvalid, m1_rvalid, e.id, e.data);
        end
        tick();
    endtask

    task automatic test_write();
        rd_exp_t e;
        drive_m1(1'b1, 32'h20, 4'b1100, 32'hDEAD_BEEF);
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt, sram_cs, sram_web, sram_a, sram_di} !== {3'b011, 4'b1100, 14'd8, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL write_sram: gnt %b%b cs %b web %b a %0d di %h", m0_gnt, m1_gnt, sram_cs, sram_web, sram_a, sram_di);
        end
        exp_mem[8] = {exp_mem[8][31:16], 16'hBEEF};
        tick();
        drive_m1(1'b0, 32'h0, WEB_READ, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({m0_rvalid, m1_rvalid} !== 2'b00 || sram_di !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL write_no_rvalid[%0d]: rv %b%b di %h want 00 deadbeef", i, m0_rvalid, m1_rvalid, sram_di);
            end
            tick();
        end
        drive_m0(1'b1, 32'h20, WEB_READ, 32'h0);
        @(negedge clk);
        sb.push_back('{id: 1'b0, data: exp_mem[8]});
        tick();
        drive_m0(1'b0, 32'h0, WEB_READ, 32'h0);
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== e.data) begin
            n_fail++;
            $display("FAIL write_readback: rv %b data %h want 1 %h", m0_rvalid, m0_rdata, e.data);
        end
        tick();
    endtask

    task automatic test_run_cap();
        rd_exp_t     e;
        logic        w;
        logic [31:0] a0, a1, aw;
        int          wait0, max_wait;
        do_reset();
        a0 = 32'h200; a1 = 32'h100; wait0 = 0; max_wait = 0;
        for (int i = 0; i < 12; i++) begin
            drive_m0(i >= 4, a0, WEB_READ, 32'h0);
            drive_m1(1'b1, a1, WEB_READ, 32'h0);
            @(negedge clk);
            w  = (i < 4) ? 1'b1 : (((i - 4) % 2) != 0);
            aw = w ? a1 : a0;
            n_checks++;
            if ({m0_gnt, m1_gnt} !== (w ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL cap_gnt[%0d]: gnt %b%b want m%0d", i, m0_gnt, m1_gnt, w);
            end
            if (i >= 4) begin
                wait0 = m0_gnt ? 0 : wait0 + 1;
                if (wait0 > max_wait) max_wait = wait0;
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_checks++;
                if ({m0_rvalid, m1_rvalid} !== (e.id ? 2'b01 : 2'b10) || (e.id ? m1_rdata : m0_rdata) !== e.data) begin
                    n_fail++;
                    $display("FAIL cap_rvalid[%0d]: rv %b%b data %h/%h want m%0d %h", i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, e.id, e.data);
                end
            end
            sb.push_back('{id: w, data: exp_mem[aw[9:2]]});
            if (w) a1 = a1 + 32'd4; else a0 = a0 + 32'd4;
            tick();
        end
        n_checks++;
        if (max_wait > MAX_RUN) begin
            n_fail++;
            $display("FAIL cap_starve: m0 waited %0d cycles, limit %0d", max_wait, MAX_RUN);
        end
        drive_m0(1'b0, 32'h0, WEB_READ, 32'h0);
        drive_m1(1'b0, 32'h0, WEB_READ, 32'h0);
        tick();
        sb.delete();
    endtask

    task automatic test_reset_mid_read();
        drive_m0(1'b1, 32'h30, WEB_READ, 32'h0);
        @(negedge clk);
        n_checks++;
        if (m0_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_gnt: got %b want 1", m0_gnt);
        end
        tick();
        rst = 1'b1;
        drive_m0(1'b0, 32'h0, WEB_READ, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_cs, sram_web, sram_a, sram_di, m0_rdata, m1_rdata}
            !== {4'b0000, 1'b0, 4'hF, {(ADDR_W+96){1'b0}}}) begin
            n_fail++;
            $display("FAIL midrst_outputs: rv %b%b cs %b web %h a %h di %h rd %h", m0_rvalid, m1_rvalid, sram_cs, sram_web, sram_a, sram_di, m0_rdata);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({m0_rvalid, m1_rvalid} !== 2'b00) begin
                n_fail++;
                $display("FAIL midrst_dropped[%0d]: rv %b%b want 00", i, m0_rvalid, m1_rvalid);
            end
            tick();
        end
    endtask

    task automatic test_pick_exhaustive();
        logic [7:0] v;
        logic       w, e0, e1;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            {pk_req0, pk_req1, pk_prio, pk_last, pk_run} = v;
            #1;
            if (pk_req0 && pk_req1) begin
                w  = (pk_run == 4'(MAX_RUN)) ? ~pk_last : pk_prio;
                e0 = ~w;
                e1 = w;
            end else begin
                e0 = pk_req0;
                e1 = pk_req1;
            end
            n_checks++;
            if ({pk_gnt0, pk_gnt1} !== {e0, e1}) begin
                n_fail++;
                $display("FAIL pick[%h]: got %b%b want %b%b", v, pk_gnt0, pk_gnt1, e0, e1);
            end
        end
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        drive_m0(1'b1, 32'h40, WEB_READ, 32'h0);
        drive_m1(1'b1, 32'h80, WEB_READ, 32'h0);
        repeat (10) tick();
        drive_m0(1'b0, 32'h0, WEB_READ, 32'h0);
        drive_m1(1'b0, 32'h0, WEB_READ, 32'h0);
        @(negedge clk);
        n_checks++;
        if ({perf_conf, perf_gnt0, perf_gnt1} !== {32'd10, 32'd5, 32'd5}) begin
            n_fail++;
            $display("FAIL perf: conf %0d gnt0 %0d gnt1 %0d want 10 5 5", perf_conf, perf_gnt0, perf_gnt1);
        end
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        init_mem = 1'b1;
        {pk_req0, pk_req1, pk_prio, pk_last, pk_run} = 8'h0;
        drive_m0(1'b0, 32'h0, WEB_READ, 32'h0);
        drive_m1(1'b0, 32'h0, WEB_READ, 32'h0);
        for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
        test_reset();
        test_single_read();
        test_back_to_back();
        test_write();
        test_run_cap();
        test_reset_mid_read();
        test_pick_exhaustive();
`ifdef MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
